wrr_arbiter: RTL and testbench



---
 rtl/cf_math_pkg.sv | 9 +
 rtl/lzc.sv | 31 +++
 rtl/wrr_arbiter.sv | 129 ++++++++++++
 tb/tb_wrr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cf_math_pkg.sv
// Shared math helpers for parametrised blocks.
// idx_width(n): bits needed to index n items (at least 1).
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter.
// in_i: vector; cnt_o: zero count (index of first set bit
// from LSB in trailing mode); empty_o: no bit set.
module lzc
  import cf_math_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter bit MODE = 1'b0,
  localparam int unsigned CntWidth = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0]    in_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                empty_o
);

  always_comb begin
    cnt_o = '0;
    if (!MODE) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CntWidth'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CntWidth'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with payload mux and lock-in.
// Ports: clk_i, rst_i (async, high), flush_i; weight_i, req_i,
// data_i per input; req_o/gnt_i downstream handshake; gnt_o
// one-hot grant on transfer; data_o/idx_o of the selection.
module wrr_arbiter
  import cf_math_pkg::*;
#(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter bit          LockIn      = 1'b1,
  localparam int unsigned IdxWidth   = idx_width(NumIn)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  input  logic [NumIn-1:0]             req_i,
  input  logic [NumIn*DataWidth-1:0]   data_i,
  output logic [NumIn-1:0]             gnt_o,
  output logic                         req_o,
  input  logic                         gnt_i,
  output logic [DataWidth-1:0]         data_o,
  output logic [IdxWidth-1:0]          idx_o
);

  localparam logic [WeightWidth:0] CntOne =
    (WeightWidth + 1)'(1);

  logic [IdxWidth-1:0]    rr_q, lidx_q;
  logic [WeightWidth-1:0] cnt_q;
  logic                   lock_q;

  logic [NumIn-1:0]       mask, req_m;
  logic [IdxWidth-1:0]    idx_m, idx_u, sel, rr_nxt;
  logic                   empty_m, empty_u;
  logic                   xfer, last, lock_hold;
  logic [WeightWidth-1:0] w_sel, w_eff;
  logic [WeightWidth:0]   n_cnt;

  // Requests at or above the pointer win first; the
  // unmasked search provides the wrap-around.
  always_comb begin
    mask = '0;
    for (int k = 0; k < NumIn; k++) begin
      mask[k] = (k >= int'(rr_q));
    end
  end

  assign req_m = req_i & mask;

  lzc #(.WIDTH(NumIn), .MODE(1'b0)) u_lzc_m (
    .in_i   (req_m),
    .cnt_o  (idx_m),
    .empty_o(empty_m)
  );

  lzc #(.WIDTH(NumIn), .MODE(1'b0)) u_lzc_u (
    .in_i   (req_i),
    .cnt_o  (idx_u),
    .empty_o(empty_u)
  );

  always_comb begin
    if (lock_q)       sel = lidx_q;
    else if (!empty_m) sel = idx_m;
    else              sel = idx_u;
  end

  assign req_o = ~empty_u | lock_q;
  assign xfer  = req_o & gnt_i;
  assign idx_o = req_o ? sel : '0;

  always_comb begin
    gnt_o     = '0;
    data_o    = '0;
    w_sel     = '0;
    lock_hold = 1'b1;
    for (int k = 0; k < NumIn; k++) begin
      if (sel == IdxWidth'(k)) begin
        gnt_o[k] = xfer;
        w_sel    = weight_i[k*WeightWidth +: WeightWidth];
        if (req_o) data_o = data_i[k*DataWidth +: DataWidth];
      end
      if (lidx_q == IdxWidth'(k)) lock_hold = req_i[k];
    end
  end

  // A weight of 0 behaves as 1; the burst continues only
  // while the same input keeps winning at the pointer.
  assign w_eff  = (w_sel == '0) ? WeightWidth'(1) : w_sel;
  assign n_cnt  = (sel == rr_q) ? {1'b0, cnt_q} + CntOne
                                : CntOne;
  assign last   = n_cnt >= {1'b0, w_eff};
  assign rr_nxt = (sel == IdxWidth'(NumIn - 1))
                  ? '0 : sel + IdxWidth'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
    end else if (flush_i) begin
      rr_q   <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
    end else if (xfer) begin
      lock_q <= 1'b0;
      if (last) begin
        rr_q  <= rr_nxt;
        cnt_q <= '0;
      end else begin
        rr_q  <= sel;
        cnt_q <= n_cnt[WeightWidth-1:0];
      end
    end else if (LockIn && req_o && !lock_q) begin
      lock_q <= 1'b1;
      lidx_q <= sel;
    end
  end

  a_lock_hold: assert property (
    @(posedge clk_i) disable iff (rst_i)
    lock_q |-> lock_hold
  );

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: NumIn=4 and NumIn=3 instances,
// per-cycle reference model plus literal sequence checks.
module tb_wrr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---- NumIn = 4 instance ----
  logic [3:0]   req4 = '0;
  logic         g4 = 1'b0, fl4 = 1'b0;
  logic [15:0]  w4 = 16'h1111;
  logic [127:0] d4v = {32'hD3D3_0003, 32'hC2C2_0002,
                       32'hB1B1_0001, 32'hA0A0_0000};
  logic [3:0]   gnt4;
  logic         ro4;
  logic [31:0]  do4;
  logic [1:0]   idx4;

  wrr_arbiter #(
    .NumIn(4), .DataWidth(32), .WeightWidth(4), .LockIn(1'b1)
  ) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl4),
    .weight_i(w4), .req_i(req4), .data_i(d4v),
    .gnt_o(gnt4), .req_o(ro4), .gnt_i(g4),
    .data_o(do4), .idx_o(idx4)
  );

  // ---- NumIn = 3 instance ----
  logic [2:0]  req3 = '0;
  logic        g3 = 1'b0, fl3 = 1'b0;
  logic [11:0] w3 = 12'h111;
  logic [23:0] d3v = {8'h33, 8'h22, 8'h11};
  logic [2:0]  gnt3;
  logic        ro3;
  logic [7:0]  do3;
  logic [1:0]  idx3;

  wrr_arbiter #(
    .NumIn(3), .DataWidth(8), .WeightWidth(4), .LockIn(1'b1)
  ) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl3),
    .weight_i(w3), .req_i(req3), .data_i(d3v),
    .gnt_o(gnt3), .req_o(ro3), .gnt_i(g3),
    .data_o(do3), .idx_o(idx3)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---- reference model ----
  typedef struct packed {
    int ptr;
    int cnt;
    bit lk;
    int lidx;
  } mst_t;

  mst_t s4 = '0, s3 = '0;

  // Cyclic scan from the pointer; -1 when nothing requests.
  function automatic int m_sel(mst_t s, int n, logic [3:0] r);
    int kk;
    if (s.lk) return s.lidx;
    for (int off = 0; off < n; off++) begin
      kk = (s.ptr + off) % n;
      if (r[kk]) return kk;
    end
    return -1;
  endfunction

  function automatic mst_t m_next(mst_t s, int n,
                                  logic [3:0] r, logic [15:0] w,
                                  bit g, bit fl);
    mst_t o = s;
    int k, nb, wk;
    k = m_sel(s, n, r);
    if (k >= 0 && g) begin
      nb = (k == s.ptr) ? s.cnt + 1 : 1;
      wk = int'(w[k*4 +: 4]);
      if (wk == 0) wk = 1;
      if (nb >= wk) begin
        o.ptr = (k + 1) % n;
        o.cnt = 0;
      end else begin
        o.ptr = k;
        o.cnt = nb;
      end
      o.lk = 1'b0;
    end else if (k >= 0 && !s.lk) begin
      o.lk   = 1'b1;
      o.lidx = k;
    end
    if (fl) o = '0;
    return o;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s4 <= '0;
      s3 <= '0;
    end else begin
      s4 <= m_next(s4, 4, req4, w4, g4, fl4);
      s3 <= m_next(s3, 3, {1'b0, req3}, {4'h0, w3}, g3, fl3);
    end
  end

  int k4, k3;

  always @(negedge clk) begin
    if (!rst) begin
      k4 = m_sel(s4, 4, req4);
      chk("m4_req", ro4, k4 >= 0);
      chk("m4_idx", idx4, k4 >= 0 ? k4 : 0);
      chk("m4_gnt", gnt4, (k4 >= 0 && g4) ? 64'd1 << k4 : 0);
      chk("m4_dat", do4, k4 >= 0 ? d4v[k4*32 +: 32] : 0);
      k3 = m_sel(s3, 3, {1'b0, req3});
      chk("m3_req", ro3, k3 >= 0);
      chk("m3_idx", idx3, k3 >= 0 ? k3 : 0);
      chk("m3_gnt", gnt3, (k3 >= 0 && g3) ? 64'd1 << k3 : 0);
      chk("m3_dat", do3, k3 >= 0 ? d3v[k3*8 +: 8] : 0);
    end
  end

  // ---- directed stimulus ----
  task automatic drv4(input logic [3:0] r, input logic g,
                      input logic f, input logic [15:0] w);
    @(posedge clk);
    #1;
    req4 = r; g4 = g; fl4 = f; w4 = w;
    @(negedge clk);
  endtask

  task automatic drv3(input logic [2:0] r, input logic g);
    @(posedge clk);
    #1;
    req3 = r; g3 = g;
    @(negedge clk);
  endtask

  int exp_b[10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
  int exp_3[5]  = '{0, 2, 0, 2, 0};

  initial begin
    #12 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", ro4, 0);
    chk("rst_gnt", gnt4, 0);
    chk("rst_idx", idx4, 0);
    chk("rst_dat", do4, 0);

    // equal weights: plain round robin
    for (int i = 0; i < 8; i++) begin
      drv4(4'hF, 1'b1, 1'b0, 16'h1111);
      chk("rr_idx", idx4, i % 4);
      chk("rr_gnt", gnt4, 64'd1 << (i % 4));
      if (i == 0) chk("rr_dat", do4, 32'hA0A0_0000);
    end

    // weights {3,1,2,0}
    for (int i = 0; i < 10; i++) begin
      drv4(4'hF, 1'b1, 1'b0, 16'h0213);
      chk("wt_idx", idx4, exp_b[i]);
    end

    // lock-in while stalled
    drv4(4'h0, 1'b0, 1'b1, 16'h0213);
    for (int i = 0; i < 3; i++) begin
      drv4(4'b0110, 1'b0, 1'b0, 16'h0213);
      chk("lk_idx", idx4, 1);
      chk("lk_gnt", gnt4, 0);
    end
    drv4(4'b0111, 1'b0, 1'b0, 16'h0213);
    chk("lk_hold", idx4, 1);
    drv4(4'b0111, 1'b1, 1'b0, 16'h0213);
    chk("lk_rel_idx", idx4, 1);
    chk("lk_rel_gnt", gnt4, 4'b0010);

    // weight lowered mid-burst ends the burst
    drv4(4'h0, 1'b0, 1'b1, 16'h0213);
    drv4(4'hF, 1'b1, 1'b0, 16'h0213);
    chk("mb_0", idx4, 0);
    drv4(4'hF, 1'b1, 1'b0, 16'h0211);
    chk("mb_1", idx4, 0);
    drv4(4'hF, 1'b1, 1'b0, 16'h0211);
    chk("mb_2", idx4, 1);

    // flush beats a same-cycle transfer
    drv4(4'h0, 1'b0, 1'b1, 16'h0211);
    drv4(4'b0100, 1'b1, 1'b1, 16'h0211);
    chk("fl_gnt", gnt4, 4'b0100);
    chk("fl_idx", idx4, 2);
    drv4(4'hF, 1'b1, 1'b0, 16'h0211);
    chk("fl_next", idx4, 0);

    // flush drops a lock
    drv4(4'b0110, 1'b0, 1'b0, 16'h0211);
    chk("fl_lk0", idx4, 1);
    drv4(4'b0110, 1'b0, 1'b1, 16'h0211);
    chk("fl_lk1", idx4, 1);
    drv4(4'hF, 1'b1, 1'b0, 16'h0211);
    chk("fl_lk2", idx4, 0);
    drv4(4'h0, 1'b0, 1'b0, 16'h0211);

    // NumIn=3 wrap and async reset
    for (int i = 0; i < 5; i++) begin
      drv3(3'b101, 1'b1);
      chk("n3_idx", idx3, exp_3[i]);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("n3_rst", idx3, 0);
    drv3(3'b101, 1'b1);
    chk("n3_after", idx3, 2);
    drv3(3'b000, 1'b0);
    chk("n3_idle", ro3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
